// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: burst-locking N-to-1 arbiter for the cache bus.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W =
    (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_idx
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] grant_nx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick;
  logic             pick_ok;
  logic             done;

  function automatic logic [IDX_W-1:0] wrap_inc(
    logic [IDX_W-1:0] a,
    int               b
  );
    int s;
    s = int'(a) + b;
    if (s >= NUM_INPUTS) s = s - NUM_INPUTS;
    return IDX_W'(s);
  endfunction

  // first valid master scanning upward from rr_ptr
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!pick_ok && ireqs[wrap_inc(rr_ptr, k)].valid) begin
        pick    = wrap_inc(rr_ptr, k);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_idx;
    done     = 1'b0;
    oreq     = '0;
    iresps   = '0;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nx = BUSY;
          grant_nx = pick;
        end
      end
      BUSY: begin
        oreq              = ireqs[grant_idx];
        iresps[grant_idx] = oresp;
        // a master dropping valid mid-burst aborts its grant
        done = (oresp.ready && oresp.last) ||
               !ireqs[grant_idx].valid;
        if (done) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant_idx <= '0;
    end else begin
      state     <= state_nx;
      grant_idx <= grant_nx;
    end
  end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (done) begin
      rr_ptr <= wrap_inc(grant_idx, 1);
    end
  end
`else
  assign rr_ptr = '0;
`endif

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed and randomized checks of cbus_rr_arbiter
// against a priority-distance reference model.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                   clk;
  logic                   reset;
  cbus_req_t  [1:0]       ireqs;
  cbus_resp_t [1:0]       iresps;
  cbus_req_t              oreq;
  cbus_resp_t             oresp;
  logic                   busy;
  logic [0:0]             grant_idx;

  int n_checks;
  int n_fail;

  cbus_rr_arbiter #(.NUM_INPUTS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cbus_req_t mk_req(
    logic w, logic [31:0] a, logic [7:0] l
  );
    cbus_req_t q;
    q          = '0;
    q.valid    = 1'b1;
    q.is_write = w;
    q.size     = 2'd2;
    q.addr     = a;
    q.strobe   = w ? 4'hf : 4'h0;
    q.data     = $urandom;
    q.len      = l;
    q.burst    = (l != 8'd0) ? 2'd1 : 2'd0;
    return q;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ireqs = '0;
    oresp = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ireqs = '0;
    oresp = '0;
    @(negedge clk);
    reset = 1'b0;
    ireqs[0] = mk_req(1'b0, 32'h1000, 8'd0);
    ireqs[1] = mk_req(1'b0, 32'h2000, 8'd0);
    oresp.ready = 1'b1;
    oresp.data  = 32'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (oreq.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_oreq_valid: got %b expected 0", oreq.valid);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (iresps[0].ready !== 1'b0 || iresps[1].ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: got %b%b expected 00",
               iresps[1].ready, iresps[0].ready);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || grant_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release_grant: got busy=%b idx=%0d expected busy=1 idx=0",
               busy, grant_idx);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    @(posedge clk); #1;
    ireqs[1] = mk_req(1'b0, 32'h80001000, 8'd0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || oreq.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b valid=%b expected 0/0",
               busy, oreq.valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (oreq.valid !== 1'b1 || oreq.addr !== 32'h80001000 ||
        grant_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_oreq: got v=%b a=%h idx=%0d expected v=1 a=80001000 idx=1",
               oreq.valid, oreq.addr, grant_idx);
    end
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (iresps[1].data !== 32'hDEADBEEF || iresps[1].ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_resp: got r=%b d=%h expected r=1 d=deadbeef",
               iresps[1].ready, iresps[1].data);
    end
    n_checks++;
    if (iresps[0] !== '0) begin
      n_fail++;
      $display("FAIL single_other: got %h expected 0", iresps[0]);
    end
    @(posedge clk); #1;
    ireqs = '0;
    oresp = '0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    @(posedge clk); #1;
    ireqs[0] = mk_req(1'b0, 32'h80002000, 8'd3);
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) ireqs[1] = mk_req(1'b0, 32'h80003000, 8'd0);
      oresp.ready = 1'b1;
      oresp.last  = (b == 3);
      oresp.data  = 32'hA000 + b;
      @(negedge clk);
      n_checks++;
      if (iresps[1].ready !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_m1_ready beat %0d: got %b expected 0",
                 b, iresps[1].ready);
      end
      n_checks++;
      if (iresps[0].ready !== 1'b1 || iresps[0].data !== 32'hA000 + b ||
          grant_idx !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_m0_beat %0d: got r=%b d=%h idx=%0d expected r=1 d=%h idx=0",
                 b, iresps[0].ready, iresps[0].data, grant_idx, 32'hA000 + b);
      end
      @(posedge clk); #1;
    end
    ireqs[0]   = '0;
    oresp.last = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || iresps[1].ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_bubble: got busy=%b r1=%b expected 0/0",
               busy, iresps[1].ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || grant_idx !== 1'b1 || iresps[1].ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_m1_grant: got busy=%b idx=%0d r1=%b expected 1/1/1",
               busy, grant_idx, iresps[1].ready);
    end
  endtask

  task automatic test_fairness();
    int bursts;
    int exp_g;
    do_reset();
    @(posedge clk); #1;
    ireqs[0]    = mk_req(1'b0, 32'h100, 8'd0);
    ireqs[1]    = mk_req(1'b0, 32'h200, 8'd0);
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    bursts = 0;
    for (int c = 0; c < 40 && bursts < 8; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        exp_g = RR ? (bursts % 2) : 0;
        n_checks++;
        if (grant_idx !== 1'(exp_g)) begin
          n_fail++;
          $display("FAIL fair_grant %0d: got %0d expected %0d",
                   bursts, grant_idx, exp_g);
        end
        bursts++;
      end
    end
    n_checks++;
    if (bursts != 8) begin
      n_fail++;
      $display("FAIL fair_bursts: got %0d expected 8", bursts);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(posedge clk); #1;
    ireqs[0] = mk_req(1'b0, 32'h300, 8'd0);
    @(posedge clk); #1;
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    @(posedge clk); #1;
    ireqs[0] = '0;
    oresp    = '0;
    ireqs[1] = mk_req(1'b1, 32'h400, 8'd7);
    @(posedge clk); #1;
    oresp.ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (oreq.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got valid=%b expected 1", oreq.valid);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (oreq.valid !== 1'b0 || busy !== 1'b0 || iresps[1].ready !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_drop: got v=%b busy=%b r1=%b expected 0/0/0",
               oreq.valid, busy, iresps[1].ready);
    end
    ireqs[0] = mk_req(1'b0, 32'h500, 8'd0);
    oresp    = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_idle: got busy=%b expected 0", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || grant_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_rr: got busy=%b idx=%0d expected 1/0",
               busy, grant_idx);
    end
  endtask

  task automatic test_abort();
    do_reset();
    @(posedge clk); #1;
    ireqs[0] = mk_req(1'b0, 32'h600, 8'd3);
    ireqs[1] = mk_req(1'b0, 32'h700, 8'd0);
    @(posedge clk); #1;
    oresp.ready = 1'b1;
    @(posedge clk); #1;
    ireqs[0].valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (oreq.valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_live: got v=%b busy=%b expected 0/1",
               oreq.valid, busy);
    end
    @(posedge clk); #1;
    ireqs[0] = '0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b expected 0", busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || grant_idx !== 1'b1 ||
        iresps[1].ready !== 1'b1 || iresps[0].ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next: got busy=%b idx=%0d r=%b%b expected 1/1/10",
               busy, grant_idx, iresps[1].ready, iresps[0].ready);
    end
  endtask

  task automatic test_random();
    bit          v[2];
    bit          dn[2];
    logic [7:0]  ln[2];
    logic [31:0] ad[2];
    bit          m_busy;
    int          m_gnt;
    int          m_rr;
    int          beat;
    int          best;
    int          bd;
    int          d;
    bit          r;
    logic [31:0] rd;
    do_reset();
    m_busy = 0; m_gnt = 0; m_rr = 0; beat = 0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; dn[i] = 0; ln[i] = '0; ad[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (dn[i]) begin
          v[i] = 0;
          dn[i] = 0;
        end else if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i]  = 1;
          ln[i] = 8'($urandom_range(0, 3));
          ad[i] = $urandom;
        end
        ireqs[i] = v[i] ?
          mk_req(1'($urandom_range(0, 1)), ad[i], ln[i]) : '0;
      end
      if (m_busy) begin
        r = ($urandom_range(0, 2) != 0);
        oresp.ready = r;
        oresp.last  = r && (beat == int'(ln[m_gnt]));
      end else begin
        r = 0;
        oresp.ready = 1'($urandom_range(0, 1));
        oresp.last  = 1'($urandom_range(0, 1));
      end
      rd = $urandom;
      oresp.data = rd;
      @(negedge clk);
      n_checks++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, m_busy);
      end
      if (m_busy) begin
        n_checks++;
        if (grant_idx !== 1'(m_gnt) || oreq.addr !== ad[m_gnt]) begin
          n_fail++;
          $display("FAIL rnd_grant c%0d: got idx=%0d a=%h expected idx=%0d a=%h",
                   c, grant_idx, oreq.addr, m_gnt, ad[m_gnt]);
        end
        n_checks++;
        if (iresps[m_gnt].ready !== r || iresps[m_gnt].data !== rd ||
            iresps[1 - m_gnt].ready !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_resp c%0d: got r=%b d=%h other=%b expected r=%b d=%h other=0",
                   c, iresps[m_gnt].ready, iresps[m_gnt].data,
                   iresps[1 - m_gnt].ready, r, rd);
        end
      end else begin
        n_checks++;
        if (oreq !== '0 || iresps !== '0) begin
          n_fail++;
          $display("FAIL rnd_idle_out c%0d: got v=%b r=%b%b expected zero",
                   c, oreq.valid, iresps[1].ready, iresps[0].ready);
        end
      end
      if (m_busy) begin
        if (r) begin
          if (beat == int'(ln[m_gnt])) begin
            dn[m_gnt] = 1;
            m_busy    = 0;
            m_rr      = (m_gnt + 1) % 2;
            beat      = 0;
          end else begin
            beat++;
          end
        end
      end else begin
        best = -1;
        bd   = 2;
        for (int i = 0; i < 2; i++) begin
          if (v[i]) begin
            d = RR ? ((i - m_rr + 2) % 2) : i;
            if (d < bd) begin
              bd   = d;
              best = i;
            end
          end
        end
        if (best >= 0) begin
          m_busy = 1;
          m_gnt  = best;
          beat   = 0;
        end
      end
    end
    @(posedge clk); #1;
    ireqs = '0;
    oresp = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ireqs    = '0;
    oresp    = '0;
    test_reset();
    test_single_read();
    test_burst_lock();
    test_fairness();
    test_async_reset();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
